// File: rtl/pwm_top.sv
// PWM generator with run-time programmable frequency and duty.
// A shared restoring divider derives the period P = CLK_FREQ_HZ / frequency
// and the high time H = P * duty / 100. When the inputs change during RUN it
// recomputes them in the background, and the new values are swapped in at a
// period wrap.
module pwm_top #(
  parameter logic [31:0] CLK_FREQ_HZ = 32'd100_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  duty_cycle,
  input  logic [15:0] frequency,
  output logic        pwm_out
);

  localparam logic [1:0] S_LOAD   = 2'd0;
  localparam logic [1:0] S_CALC_P = 2'd1;
  localparam logic [1:0] S_CALC_H = 2'd2;
  localparam logic [1:0] S_RUN    = 2'd3;

  logic [1:0]  state;
  logic [6:0]  duty_sh;
  logic [15:0] freq_sh;
  logic [31:0] p_reg, h_reg;   // values driving the waveform
  logic [31:0] p_new, h_new;   // freshly computed values awaiting a wrap
  logic        upd_pending;
  logic [31:0] cnt;

  // Divider state: the dividend shifts out MSB-first into the remainder.
  logic        div_busy;
  logic        div_h;          // 0: computing P, 1: computing H
  logic [5:0]  div_cnt;        // iterations left
  logic [38:0] div_num;
  logic [38:0] div_quo;
  logic [15:0] div_rem;
  logic [15:0] div_den;

  logic [6:0]  duty_clamp;
  logic        inputs_changed;
  logic [16:0] rem_sh, rem_nx;
  logic        rem_ge;
  logic [38:0] quo_nx;
  logic [31:0] p_fix;
  logic [38:0] prod;
  logic        div_last;
  logic        start_p;
  logic        stop_div;

  // Clamp duty, run one divider iteration and decide divider start/abort.
  always_comb begin
    duty_clamp     = (duty_cycle > 7'd100) ? 7'd100 : duty_cycle;
    inputs_changed = (duty_clamp != duty_sh) || (frequency != freq_sh);
    rem_sh         = {div_rem, div_num[38]};
    rem_ge         = (rem_sh >= {1'b0, div_den});
    rem_nx         = rem_ge ? (rem_sh - {1'b0, div_den}) : rem_sh;
    quo_nx         = {div_quo[37:0], rem_ge};
    // A zero quotient (frequency above the clock) still needs a 1-cycle period.
    p_fix          = (quo_nx[31:0] == 32'd0) ? 32'd1 : quo_nx[31:0];
    prod           = {7'd0, p_fix} * {32'd0, duty_sh};
    div_last       = div_busy && (div_cnt == 6'd1);
    start_p        = (frequency != 16'd0) &&
                     ((state == S_LOAD) || ((state == S_RUN) && inputs_changed));
    stop_div       = (state == S_RUN) && inputs_changed && (frequency == 16'd0);
  end

  // Control FSM, divider sequencing and the PWM counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_LOAD;
      pwm_out     <= 1'b0;
      cnt         <= 32'd0;
      duty_sh     <= 7'd0;
      freq_sh     <= 16'd0;
      p_reg       <= 32'd0;
      h_reg       <= 32'd0;
      p_new       <= 32'd0;
      h_new       <= 32'd0;
      upd_pending <= 1'b0;
      div_busy    <= 1'b0;
      div_h       <= 1'b0;
      div_cnt     <= 6'd0;
      div_num     <= 39'd0;
      div_quo     <= 39'd0;
      div_rem     <= 16'd0;
      div_den     <= 16'd0;
    end else begin
      if (div_busy) begin
        div_rem <= rem_nx[15:0];
        div_quo <= quo_nx;
        div_num <= {div_num[37:0], 1'b0};
        div_cnt <= div_cnt - 6'd1;
        if (div_last) begin
          if (!div_h) begin
            // P done: chain straight into H = P*D/100.
            p_new   <= p_fix;
            div_num <= prod;
            div_den <= 16'd100;
            div_rem <= 16'd0;
            div_quo <= 39'd0;
            div_cnt <= 6'd39;
            div_h   <= 1'b1;
          end else begin
            h_new    <= quo_nx[31:0];
            div_busy <= 1'b0;
          end
        end
      end

      if (start_p) begin
        // Dividend is left-aligned so 32 iterations consume exactly its bits.
        div_num  <= {CLK_FREQ_HZ, 7'd0};
        div_den  <= frequency;
        div_rem  <= 16'd0;
        div_quo  <= 39'd0;
        div_cnt  <= 6'd32;
        div_h    <= 1'b0;
        div_busy <= 1'b1;
      end else if (stop_div) begin
        div_busy <= 1'b0;
      end

      case (state)
        S_LOAD: begin
          duty_sh <= duty_clamp;
          freq_sh <= frequency;
          pwm_out <= 1'b0;
          cnt     <= 32'd0;
          if (frequency != 16'd0) state <= S_CALC_P;
        end
        S_CALC_P: begin
          if (div_last) state <= S_CALC_H;
        end
        S_CALC_H: begin
          if (div_last) begin
            state <= S_RUN;
            p_reg <= p_new;
            h_reg <= quo_nx[31:0];
            cnt   <= 32'd0;
          end
        end
        default: begin
          pwm_out <= (cnt < h_reg);
          if (div_last && div_h) upd_pending <= 1'b1;
          if (cnt == p_reg - 32'd1) begin
            cnt <= 32'd0;
            if (freq_sh == 16'd0) begin
              state   <= S_LOAD;
              pwm_out <= 1'b0;
            end else if (upd_pending) begin
              p_reg       <= p_new;
              h_reg       <= h_new;
              upd_pending <= 1'b0;
            end
          end else begin
            cnt <= cnt + 32'd1;
          end
          // New inputs invalidate any result not yet applied.
          if (inputs_changed) begin
            duty_sh     <= duty_clamp;
            freq_sh     <= frequency;
            upd_pending <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_top.sv
// Directed bench for pwm_top: a small-clock instance (P = 50 at 2 kHz)
// exercises the waveform, updates, limits and reset; a default-clock
// instance confirms the full-size period P = 50000, H = 12500.
module tb_pwm_top;

  logic        clk;
  logic        rst, rst_d;
  logic [6:0]  duty, duty_d;
  logic [15:0] freq, freq_d;
  logic        pwm, pwm_d;

  int n_chk;
  int n_pass;

  pwm_top #(.CLK_FREQ_HZ(32'd100_000)) u_dut (
    .clk(clk), .rst(rst), .duty_cycle(duty), .frequency(freq), .pwm_out(pwm)
  );

  pwm_top u_dut_def (
    .clk(clk), .rst(rst_d), .duty_cycle(duty_d), .frequency(freq_d), .pwm_out(pwm_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // Samples pwm for n cycles (after each rising edge) and checks every one is val.
  task automatic seg(input string tag, input int sel, input logic val, input int n);
    int good;
    good = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (((sel != 0) ? pwm_d : pwm) === val) good++;
    end
    chk(tag, good, n);
  endtask

  task automatic reset_small(input int n);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    chk("reset_pwm", int'(pwm), 0);
    rst = 1'b0;
  endtask

  // Full-size instance: latency, then two high phases and one low phase.
  task automatic run_default();
    rst_d = 1'b1;
    repeat (2) @(negedge clk);
    chk("def_reset", int'(pwm_d), 0);
    rst_d = 1'b0;
    seg("def_latency", 1, 1'b0, 72);
    seg("def_hi1", 1, 1'b1, 12500);
    seg("def_lo1", 1, 1'b0, 37500);
    seg("def_hi2", 1, 1'b1, 12500);
    seg("def_lo2_start", 1, 1'b0, 1);
  endtask

  task automatic run_small();
    // Basic waveform, 25 % at 2 kHz.
    freq = 16'd2000;
    duty = 7'd25;
    reset_small(2);
    seg("lat", 0, 1'b0, 72);
    seg("p1_hi", 0, 1'b1, 12);
    seg("p1_lo", 0, 1'b0, 38);
    seg("p2_hi", 0, 1'b1, 12);
    seg("p2_lo", 0, 1'b0, 38);
    // Duty change five cycles into a period: two more old periods, then 32/18.
    seg("p3_hi_a", 0, 1'b1, 5);
    duty = 7'd65;
    seg("p3_hi_b", 0, 1'b1, 7);
    seg("p3_lo", 0, 1'b0, 38);
    seg("p4_hi_old", 0, 1'b1, 12);
    seg("p4_lo_old", 0, 1'b0, 38);
    seg("p5_hi_new", 0, 1'b1, 32);
    seg("p5_lo_new", 0, 1'b0, 18);
    seg("p6_hi_new", 0, 1'b1, 32);
    seg("p6_lo_new", 0, 1'b0, 18);

    // Full duty, also with an out-of-range value.
    duty = 7'd100;
    reset_small(2);
    seg("d100_lat", 0, 1'b0, 72);
    seg("d100_high", 0, 1'b1, 150);
    duty = 7'd120;
    reset_small(2);
    seg("d120_lat", 0, 1'b0, 72);
    seg("d120_high", 0, 1'b1, 150);
    duty = 7'd0;
    reset_small(2);
    seg("d0_low", 0, 1'b0, 222);

    // Zero frequency keeps the output off, then a capture restarts it.
    duty = 7'd25;
    freq = 16'd0;
    reset_small(2);
    seg("f0_off", 0, 1'b0, 200);
    freq = 16'd2000;
    seg("f_lat", 0, 1'b0, 72);
    seg("f_hi", 0, 1'b1, 12);
    seg("f_lo", 0, 1'b0, 38);
    // Frequency dropping to 0 mid-period finishes the period then stops.
    seg("f_hi_a", 0, 1'b1, 5);
    freq = 16'd0;
    seg("f_hi_b", 0, 1'b1, 7);
    seg("f_lo_last", 0, 1'b0, 38);
    seg("f0_off2", 0, 1'b0, 120);

    // Reset pulse during the high phase.
    freq = 16'd2000;
    reset_small(2);
    seg("r_lat", 0, 1'b0, 72);
    seg("r_hi_a", 0, 1'b1, 5);
    rst = 1'b1;
    seg("r_mid_rst", 0, 1'b0, 2);
    rst = 1'b0;
    seg("r_lat2", 0, 1'b0, 72);
    seg("r_hi", 0, 1'b1, 12);
    seg("r_lo", 0, 1'b0, 38);
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst    = 1'b1;
    rst_d  = 1'b1;
    duty   = 7'd25;
    freq   = 16'd2000;
    duty_d = 7'd25;
    freq_d = 16'd2000;
    fork
      run_small();
      run_default();
    join
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pwm_top.md
PWM_TOP -- requirements
Module: pwm_top

Interface
REQ-001 Parameter CLK_FREQ_HZ, default 100_000_000, clock frequency in Hz; SHALL be an integer from 100 to 2^32-1.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 duty_cycle  input  7  duty in percent; 0..100 valid, values above 100 SHALL be treated as 100.
REQ-005 frequency  input  16  PWM frequency in Hz, unsigned; 0 means output off.
REQ-006 pwm_out  output  1  registered PWM output.

Function
REQ-007 Operating values: P = floor(CLK_FREQ_HZ / frequency), forced to 1 if the quotient is 0; H = floor(P * D / 100), where D is the clamped duty.
- P SHALL be 32 bits; the product P*D SHALL be 39 bits.
REQ-008 States SHALL be LOAD, CALC_P, CALC_H and RUN.
REQ-009 LOAD (one cycle): register the clamped duty and frequency into shadow registers.
- Next state CALC_P, unless the captured frequency is 0.
- If the captured frequency is 0: stay in LOAD, hold pwm_out = 0.
REQ-010 CALC_P: a sequential restoring divider SHALL run for exactly 32 cycles to produce P.
REQ-011 CALC_H: the same divider SHALL run for exactly 39 cycles to produce H.
- Then enter RUN with the period counter cnt = 0.
REQ-012 Start-up latency: with frequency != 0, the first RUN cycle SHALL be exactly 72 cycles after the first clock edge with rst low (1 LOAD + 32 + 39). pwm_out SHALL stay 0 until then.
REQ-013 RUN, each cycle:
- pwm_out <= (cnt < H).
- cnt increments and wraps from P-1 to 0.
- pwm_out SHALL therefore be high for exactly H and low for exactly P-H consecutive cycles in every period.
REQ-014 Limits in RUN: H = 0 SHALL give pwm_out constantly 0; H = P SHALL give pwm_out constantly 1, with no glitch at wrap.
REQ-015 Input change while in RUN (clamped duty or frequency differs from the shadow values):
- The divider SHALL recompute P and H in the background.
- Output SHALL continue with the old P and H meanwhile.
REQ-016 Updated P and H SHALL take effect only at the next wrap (cnt = P_old-1 -> 0) after the background computation completes. The new period SHALL start with cnt = 0.
REQ-017 Further input changes during a background computation SHALL restart that computation with the latest values.
REQ-018 frequency becoming 0 while in RUN SHALL take effect at the next wrap: return to LOAD with pwm_out = 0.
REQ-019 Inputs are assumed synchronous to clk; no internal synchronizers.

Reset
REQ-020 While rst is high on a clock edge, the block SHALL apply reset:
- pwm_out = 0, cnt = 0, state = LOAD.
- Shadow registers, P, H and divider state cleared; any background computation aborted.
REQ-021 Reset asserted mid-period SHALL force pwm_out to 0 on that same clock edge.
REQ-022 After rst goes low, operation SHALL restart from LOAD with the full start-up latency of REQ-012.

Verification
REQ-023 CLK_FREQ_HZ = 100_000, frequency = 2000, duty = 25, reset 2 cycles then released:
- pwm_out = 0 for the 72-cycle start-up latency, then repeating 12 high / 38 low (P = 50, H = 12).
REQ-024 Same settings, duty changed to 65 mid-period:
- Current period finishes as 12/38.
- Once recompute is done, from the next wrap: 32 high / 18 low.
REQ-025 duty = 100 (also with duty = 120):
- pwm_out constantly 1 after the latency, no low cycle at wraps.
- duty = 0: pwm_out constantly 0.
REQ-026 frequency = 0: pwm_out stays 0 indefinitely.
- Then frequency = 2000: normal waveform begins 72 cycles after the first LOAD cycle that captures it.
REQ-027 rst pulsed mid-high phase:
- pwm_out = 0 from that edge.
- After release, pwm_out rises exactly 72 cycles after the first edge with rst low.
REQ-028 Default CLK_FREQ_HZ, frequency = 2000, duty = 25: P = 50000, H = 12500, checked over 2 periods.
